// File: rtl/updown_counter_param.sv
// ============================================================================
//  Module      : updown_counter_param
//  Description : Parametrised up/down counter with runtime modulus, variable
//                step, synchronous load and three boundary modes (wrap,
//                saturate, one-shot). A registered terminal-count pulse marks
//                every boundary crossing.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1       clock, rising edge
//    reset     in   1       asynchronous, active-low reset
//    enable    in   1       count enable, one step per cycle
//    dir       in   1       0 = up, 1 = down
//    mode      in   2       00 wrap, 01 saturate, 10 one-shot, 11 wrap
//    step      in   STEP_W  unsigned increment magnitude
//    max_val   in   WIDTH   upper bound of the legal range 0..max_val
//    load      in   1       synchronous load strobe (beats enable)
//    load_val  in   WIDTH   value to load, clamped to max_val
//    count_out out  WIDTH   registered count
//    tc        out  1       registered one-cycle boundary-crossing pulse
//    halted    out  1       one-shot bound reached, counting frozen
//    at_max    out  1       count_out == max_val
//    at_min    out  1       count_out == 0
// ============================================================================
`default_nettype none

module updown_counter_param #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              dir,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count_out,
  output logic              tc,
  output logic              halted,
  output logic              at_max,
  output logic              at_min
);

  localparam logic [1:0] MODE_WRAP = 2'b00;
  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             halted_q, halted_d;

  // One extra bit so sums and wrap corrections never truncate.
  logic [WIDTH:0] max_ext;
  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] s_eff;
  logic [WIDTH:0] sum_up;
  logic [WIDTH:0] wrap_up;
  logic [WIDTH:0] wrap_dn;
  logic [WIDTH:0] diff_dn;
  logic           is_wrap;

  always_comb begin
    max_ext  = {1'b0, max_val};
    cnt_ext  = {1'b0, count_q};
    step_ext = {{(WIDTH+1-STEP_W){1'b0}}, step};
    // A step larger than the range would skip past a whole period; clamp it.
    s_eff    = (step_ext > max_ext) ? max_ext : step_ext;
    sum_up   = cnt_ext + s_eff;
    wrap_up  = sum_up - (max_ext + 1'b1);
    diff_dn  = cnt_ext - s_eff;
    wrap_dn  = cnt_ext + max_ext + 1'b1 - s_eff;
    // Encoding 11 is treated as wrap, so only sat/one-shot are special.
    is_wrap  = (mode != MODE_SAT) && (mode != MODE_ONE);
  end

  always_comb begin
    count_d  = count_q;
    tc_d     = 1'b0;
    halted_d = halted_q;

    if (load) begin
      count_d  = (load_val > max_val) ? max_val : load_val;
      halted_d = 1'b0;
    end else if (enable && !halted_q) begin
      if (count_q > max_val) begin
        // max_val was lowered under the count: pull back in range quietly.
        count_d = max_val;
      end else if (!dir) begin
        if (sum_up <= max_ext) begin
          count_d = sum_up[WIDTH-1:0];
        end else begin
          tc_d = 1'b1;
          if (is_wrap) begin
            count_d = wrap_up[WIDTH-1:0];
          end else begin
            count_d = max_val;
            if (mode == MODE_ONE) halted_d = 1'b1;
          end
        end
      end else begin
        if (cnt_ext >= s_eff) begin
          count_d = diff_dn[WIDTH-1:0];
        end else begin
          tc_d = 1'b1;
          if (is_wrap) begin
            count_d = wrap_dn[WIDTH-1:0];
          end else begin
            count_d = '0;
            if (mode == MODE_ONE) halted_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      tc_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      tc_q     <= tc_d;
      halted_q <= halted_d;
    end
  end

  assign count_out = count_q;
  assign tc        = tc_q;
  assign halted    = halted_q;
  assign at_max    = (count_q == max_val);
  assign at_min    = (count_q == '0);

  // MODE_WRAP documents the encoding; wrap is the default path.
  logic unused_mode_wrap;
  assign unused_mode_wrap = ^MODE_WRAP;

endmodule

`default_nettype wire
